// File: rtl/wrap030_bus_pkg.sv
// rtl/wrap030_bus_pkg.sv - shared state, SIZ, FC and DSACK port-width encodings for the 68030 bus master
package wrap030_bus_pkg;

  typedef logic [2:0] busState_t;

  localparam busState_t ST_IDLE  = 3'd0;
  localparam busState_t ST_S0    = 3'd1;
  localparam busState_t ST_S1    = 3'd2;
  localparam busState_t ST_S2    = 3'd3;
  localparam busState_t ST_WAIT  = 3'd4;
  localparam busState_t ST_LATCH = 3'd5;
  localparam busState_t ST_END   = 3'd6;
  localparam busState_t ST_DONE  = 3'd7;

  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;

  localparam logic [2:0] FC_USER_DATA = 3'b001;
  localparam logic [2:0] FC_USER_PROG = 3'b010;
  localparam logic [2:0] FC_SUPV_DATA = 3'b101;
  localparam logic [2:0] FC_SUPV_PROG = 3'b110;
  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  // Port widths as reported on rspPort (inverted DSACK_n)
  localparam logic [1:0] PORT_NONE  = 2'b00;
  localparam logic [1:0] PORT_BYTE  = 2'b01;
  localparam logic [1:0] PORT_WORD  = 2'b10;
  localparam logic [1:0] PORT_LONG  = 2'b11;

  function automatic logic termAsserted(input logic [1:0] dsack_n, input logic berr_n);
    return (~&dsack_n) | ~berr_n;
  endfunction

endpackage

// File: rtl/wrap030_sync.sv
// rtl/wrap030_sync.sv - parameterized multi-bit flop-chain synchronizer with async reset to a chosen value
module wrap030_sync #(
  parameter int WIDTH = 3,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             busClk,
  input  logic             busReset,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= asyncIn;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign syncOut = stage[STAGES-1];

endmodule

// File: rtl/wrap030_bus_master.sv
// rtl/wrap030_bus_master.sv - single-cycle 68030 asynchronous bus master; BUS_MASTER_TIMEOUT_EN adds a termination timeout
module wrap030_bus_master
  import wrap030_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic        busClk,
  input  logic        busReset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] reqAddr,
  input  logic        reqRW_n,
  input  logic [1:0]  reqSiz,
  input  logic [2:0]  reqFC,
  input  logic [31:0] reqWdata,
  output logic        rspValid,
  output logic [31:0] rspData,
  output logic        rspErr,
  output logic [1:0]  rspPort,
  output logic [31:0] busAddr,
  output logic [2:0]  busFC,
  output logic [1:0]  busSiz,
  output logic        busRW_n,
  output logic        busAS_n,
  output logic        busDS_n,
  output logic [31:0] busDout,
  output logic        busDoe,
  input  logic [31:0] busDin,
  input  logic [1:0]  busDsack_n,
  input  logic        busBerr_n
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : gBadSyncStages
    $error("wrap030_bus_master: SYNC_STAGES must be 2 or 3");
  end
  if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
    $error("wrap030_bus_master: TIMEOUT_CYCLES must be at least 2");
  end

  busState_t  state;
  logic [1:0] dsackSync_n;
  logic       berrSync_n;
  logic       termSeen;
  logic       released;
  logic       timedOut;

  wrap030_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RESET_VAL(3'b111)) uSync (
    .busClk  (busClk),
    .busReset(busReset),
    .asyncIn ({busDsack_n, busBerr_n}),
    .syncOut ({dsackSync_n, berrSync_n})
  );

  assign termSeen = termAsserted(dsackSync_n, berrSync_n);
  assign released = (&dsackSync_n) & berrSync_n;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] toCount;

  // Counts cycles since AS assertion; saturates once the limit is reached
  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      toCount <= '0;
    end else if (state == ST_S0) begin
      toCount <= '0;
    end else if ((state inside {ST_S1, ST_S2, ST_WAIT}) && !timedOut) begin
      toCount <= toCount + 1'b1;
    end
  end

  assign timedOut = (toCount >= CW'(TIMEOUT_CYCLES - 1));
`else
  assign timedOut = 1'b0;
`endif

  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      state   <= ST_IDLE;
      busAddr <= '0;
      busFC   <= '0;
      busSiz  <= '0;
      busRW_n <= 1'b1;
      busDout <= '0;
      rspData <= '0;
      rspErr  <= 1'b0;
      rspPort <= PORT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (reqValid) begin
            busAddr <= reqAddr;
            busFC   <= reqFC;
            busSiz  <= reqSiz;
            busRW_n <= reqRW_n;
            busDout <= reqWdata;
            rspErr  <= 1'b0;
            rspPort <= PORT_NONE;
            state   <= ST_S0;
          end
        end
        ST_S0: state <= ST_S1;
        ST_S1: state <= ST_S2;
        ST_S2: state <= ST_WAIT;
        ST_WAIT: begin
          if (termSeen) begin
            state <= ST_LATCH;
          end else if (timedOut) begin
            rspErr  <= 1'b1;
            rspPort <= PORT_NONE;
            state   <= ST_END;
          end
        end
        ST_LATCH: begin
          if (busRW_n) rspData <= busDin;
          rspPort <= ~dsackSync_n;
          rspErr  <= ~berrSync_n;
          state   <= ST_END;
        end
        ST_END:  if (released) state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so reset negates them asynchronously
  assign reqReady = (state == ST_IDLE) & ~busReset;
  assign rspValid = (state == ST_DONE);
  assign busAS_n  = ~(state inside {ST_S1, ST_S2, ST_WAIT, ST_LATCH});
  assign busDS_n  = ~(((state == ST_S1) & busRW_n) | (state inside {ST_S2, ST_WAIT, ST_LATCH}));
  assign busDoe   = ~busRW_n & (state inside {ST_S1, ST_S2, ST_WAIT, ST_LATCH, ST_END});

endmodule

// File: tb/tb_wrap030_bus_master.sv
// tb/tb_wrap030_bus_master.sv - directed self-checking bench for wrap030_bus_master
module tb_wrap030_bus_master;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic        busClk = 1'b0;
  logic        busReset;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic        reqRW_n;
  logic [1:0]  reqSiz;
  logic [2:0]  reqFC;
  logic [31:0] reqWdata;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;
  logic [1:0]  rspPort;
  logic [31:0] busAddr;
  logic [2:0]  busFC;
  logic [1:0]  busSiz;
  logic        busRW_n;
  logic        busAS_n;
  logic        busDS_n;
  logic [31:0] busDout;
  logic        busDoe;
  logic [31:0] busDin;
  logic [1:0]  busDsack_n;
  logic        busBerr_n;

  int passCount = 0;
  int checkCount = 0;
  int n;

  wrap030_bus_master #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
    .busClk(busClk), .busReset(busReset),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqRW_n(reqRW_n),
    .reqSiz(reqSiz), .reqFC(reqFC), .reqWdata(reqWdata),
    .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr), .rspPort(rspPort),
    .busAddr(busAddr), .busFC(busFC), .busSiz(busSiz), .busRW_n(busRW_n),
    .busAS_n(busAS_n), .busDS_n(busDS_n), .busDout(busDout), .busDoe(busDoe),
    .busDin(busDin), .busDsack_n(busDsack_n), .busBerr_n(busBerr_n)
  );

  always #5 busClk = ~busClk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge busClk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic rw, input logic [1:0] s,
                       input logic [2:0] f, input logic [31:0] w);
    int k = 0;
    reqAddr = a; reqRW_n = rw; reqSiz = s; reqFC = f; reqWdata = w;
    while (reqReady !== 1'b1 && k < 50) begin tick(); k++; end
    check("req_ready_bound", 32'(k < 50), 1);
    reqValid = 1'b1;
    tick();
    reqValid = 1'b0;
  endtask

  task automatic waitAsHigh(input string tag);
    int k = 0;
    while (busAS_n !== 1'b1 && k < 200) begin tick(); k++; end
    check(tag, 32'(k < 200), 1);
  endtask

  task automatic waitRsp(input string tag, output int cycles);
    int k = 0;
    while (rspValid !== 1'b1 && k < 50) begin tick(); k++; end
    check(tag, 32'(k < 50), 1);
    cycles = k;
  endtask

  initial begin
    busReset = 1'b1; reqValid = 1'b0; reqAddr = '0; reqRW_n = 1'b1; reqSiz = '0;
    reqFC = '0; reqWdata = '0; busDin = '0; busDsack_n = 2'b11; busBerr_n = 1'b1;
    repeat (3) tick();
    check("rst_as",    busAS_n, 1);
    check("rst_ds",    busDS_n, 1);
    check("rst_rw",    busRW_n, 1);
    check("rst_doe",   busDoe, 0);
    check("rst_addr",  busAddr, 0);
    check("rst_ready", reqReady, 0);
    check("rst_valid", rspValid, 0);
    check("rst_data",  rspData, 0);
    check("rst_port",  rspPort, 0);
    check("rst_err",   rspErr, 0);
    busReset = 1'b0;
    tick();
    check("idle_ready", reqReady, 1);

    // Scenario 1: long read, 32-bit port
    issue(32'h0000_1000, 1'b1, 2'b00, 3'b101, 32'h0);
    check("s1_s0_addr",  busAddr, 32'h0000_1000);
    check("s1_s0_fc",    busFC, 3'b101);
    check("s1_s0_siz",   busSiz, 2'b00);
    check("s1_s0_rw",    busRW_n, 1);
    check("s1_s0_as",    busAS_n, 1);
    check("s1_s0_ds",    busDS_n, 1);
    check("s1_s0_ready", reqReady, 0);
    tick();
    check("s1_s1_as",  busAS_n, 0);
    check("s1_s1_ds",  busDS_n, 0);
    check("s1_s1_doe", busDoe, 0);
    tick(); tick();
    busDsack_n = 2'b00; busDin = 32'hDEAD_BEEF;
    waitAsHigh("s1_as_neg_bound");
    busDsack_n = 2'b11; busDin = 32'h0;
    waitRsp("s1_rsp_bound", n);
    check("s1_data", rspData, 32'hDEAD_BEEF);
    check("s1_port", rspPort, 2'b11);
    check("s1_err",  rspErr, 0);
    check("s1_addr_hold", busAddr, 32'h0000_1000);
    tick();
    check("s1_single_pulse", rspValid, 0);
    check("s1_ready_again",  reqReady, 1);

    // Scenario 2: byte write, 16-bit port
    issue(32'h0000_0003, 1'b0, 2'b01, 3'b001, 32'h0000_005A);
    check("s2_siz",   busSiz, 2'b01);
    check("s2_rw",    busRW_n, 0);
    check("s2_dout",  busDout, 32'h5A);
    check("s2_s0_doe", busDoe, 0);
    tick();
    check("s2_s1_as",  busAS_n, 0);
    check("s2_s1_ds",  busDS_n, 1);
    check("s2_s1_doe", busDoe, 1);
    tick();
    check("s2_s2_ds",  busDS_n, 0);
    check("s2_s2_doe", busDoe, 1);
    busDsack_n = 2'b01;
    waitAsHigh("s2_as_neg_bound");
    check("s2_end_ds",  busDS_n, 1);
    check("s2_end_doe", busDoe, 1);
    busDsack_n = 2'b11;
    waitRsp("s2_rsp_bound", n);
    check("s2_done_as", busAS_n, 1);
    check("s2_done_ds", busDS_n, 1);
    check("s2_port",    rspPort, 2'b10);
    check("s2_err",     rspErr, 0);
    tick();
    check("s2_single_pulse", rspValid, 0);

    // Scenario 3: BERR and DSACK in the same cycle
    issue(32'h0000_2000, 1'b1, 2'b10, 3'b101, 32'h0);
    tick(); tick();
    busBerr_n = 1'b0; busDsack_n = 2'b10;
    waitAsHigh("s3_as_neg_bound");
    busBerr_n = 1'b1; busDsack_n = 2'b11;
    waitRsp("s3_rsp_bound", n);
    check("s3_err",  rspErr, 1);
    check("s3_port", rspPort, 2'b01);
    tick();
    check("s3_single_pulse", rspValid, 0);

    // Scenario 4: DSACK held after AS negates
    issue(32'h0000_3000, 1'b1, 2'b00, 3'b101, 32'h0);
    tick(); tick();
    busDsack_n = 2'b00; busDin = 32'h1234_5678;
    waitAsHigh("s4_as_neg_bound");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s4_hold_no_rsp", {busAS_n, rspValid}, 2'b10);
    end
    busDsack_n = 2'b11;
    n = 0;
    while (rspValid !== 1'b1 && n < 20) begin tick(); n++; end
    check("s4_release_latency", n, SYNC + 1);
    check("s4_data", rspData, 32'h1234_5678);
    tick();

    // Scenario 5: no responder
    issue(32'h0000_4000, 1'b1, 2'b00, 3'b101, 32'h0);
    tick();
    check("s5_as_start", busAS_n, 0);
`ifdef BUS_MASTER_TIMEOUT_EN
    repeat (TMO) tick();
    check("s5_timeout_as",  busAS_n, 1);
    check("s5_timeout_err", rspErr, 1);
    check("s5_timeout_port", rspPort, 2'b00);
    waitRsp("s5_rsp_bound", n);
    check("s5_rsp_err", rspErr, 1);
    tick();
    issue(32'h0000_4400, 1'b1, 2'b00, 3'b101, 32'h0);
    tick(); tick(); tick();
`else
    repeat (99) tick();
    check("s5_unbounded_as", busAS_n, 0);
`endif

    // Scenario 6: reset while waiting for termination
    check("s6_in_wait_as", busAS_n, 0);
    busReset = 1'b1;
    #1;
    check("s6_rst_as",    busAS_n, 1);
    check("s6_rst_ds",    busDS_n, 1);
    check("s6_rst_valid", rspValid, 0);
    check("s6_rst_ready", reqReady, 0);
    tick(); tick();
    check("s6_rst_hold_valid", rspValid, 0);
    busReset = 1'b0;
    tick();
    check("s6_ready_after", reqReady, 1);
    issue(32'h0000_5000, 1'b1, 2'b00, 3'b110, 32'h0);
    tick(); tick();
    busDsack_n = 2'b01; busDin = 32'hCAFE_F00D;
    waitAsHigh("s6_as_neg_bound");
    busDsack_n = 2'b11;
    waitRsp("s6_rsp_bound", n);
    check("s6_data", rspData, 32'hCAFE_F00D);
    check("s6_port", rspPort, 2'b10);
    check("s6_err",  rspErr, 0);
    tick();
    check("s6_single_pulse", rspValid, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
